arc4_seq: RTL and testbench

Top-level sequencer for the ARC4 decrypt datapath. Accepts one en/rdy request with a 24-bit key, then runs init, ksa and prga in that order using their en/rdy handshakes. It owns the single S-memory write/address port and muxes it to whichever sub-block is active. A per-phase watchdog flags a hung sub-block.

---
 rtl/arc4_seq.sv | 179 +++++++++++++++++
 tb/tb_arc4_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_seq.sv
// ARC4 decrypt sequencer: runs init, ksa and prga in order over en/rdy handshakes,
// owns the shared S-memory write port and guards each phase with a watchdog.
module arc4_seq #(
    parameter logic [31:0] TIMEOUT = 32'd65535,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        done,
    output logic        err,
    output logic [1:0]  phase,
    output logic        init_en,
    input  logic        init_rdy,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_wrdata,
    input  logic        init_wren,
    output logic        ksa_en,
    input  logic        ksa_rdy,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  ksa_wrdata,
    input  logic        ksa_wren,
    output logic        prga_en,
    input  logic        prga_rdy,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  prga_wrdata,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_GO,
        S_INIT_WAIT,
        S_KSA_GO,
        S_KSA_WAIT,
        S_PRGA_GO,
        S_PRGA_WAIT,
        S_ERR
    } state_t;

    state_t           state;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             sel_rdy;
    logic             waiting;

    // Ready of whichever sub-block owns the current phase.
    always_comb begin
        sel_rdy = 1'b0;
        case (state)
            S_INIT_GO, S_INIT_WAIT: sel_rdy = init_rdy;
            S_KSA_GO,  S_KSA_WAIT:  sel_rdy = ksa_rdy;
            S_PRGA_GO, S_PRGA_WAIT: sel_rdy = prga_rdy;
            default:                sel_rdy = 1'b0;
        endcase
    end

    always_comb begin
        waiting = (state == S_INIT_WAIT) || (state == S_KSA_WAIT) || (state == S_PRGA_WAIT);
    end

    // S-memory port follows the active phase only; idle/error parks it at zero.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (state)
            S_INIT_GO, S_INIT_WAIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            S_KSA_GO, S_KSA_WAIT: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            S_PRGA_GO, S_PRGA_WAIT: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = 8'd0;
                s_wrdata = 8'd0;
                s_wren   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rdy     <= 1'b1;
            init_en <= 1'b0;
            ksa_en  <= 1'b0;
            prga_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            key_q   <= 24'd0;
            cnt     <= '0;
            phase   <= 2'd0;
            armed   <= 1'b0;
        end else begin
            init_en <= 1'b0;
            ksa_en  <= 1'b0;
            prga_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (en) begin
                        key_q <= key;
                        err   <= 1'b0;
                        cnt   <= '0;
                        rdy   <= 1'b0;
                        phase <= 2'd1;
                        state <= S_INIT_GO;
                    end
                end
                default: begin
                    cnt <= cnt + CNT_W'(1);
                    // A rdy high only counts as completion after a low has been seen.
                    if (waiting && sel_rdy && armed) begin
                        cnt <= '0;
                        case (state)
                            S_INIT_WAIT: begin
                                state <= S_KSA_GO;
                                phase <= 2'd2;
                            end
                            S_KSA_WAIT: begin
                                state <= S_PRGA_GO;
                                phase <= 2'd3;
                            end
                            default: begin
                                state <= S_IDLE;
                                phase <= 2'd0;
                                done  <= 1'b1;
                                rdy   <= 1'b1;
                            end
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        phase <= 2'd0;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                    end else if (!waiting && sel_rdy) begin
                        armed <= 1'b0;
                        case (state)
                            S_INIT_GO: begin
                                init_en <= 1'b1;
                                state   <= S_INIT_WAIT;
                            end
                            S_KSA_GO: begin
                                ksa_en <= 1'b1;
                                state  <= S_KSA_WAIT;
                            end
                            default: begin
                                prga_en <= 1'b1;
                                state   <= S_PRGA_WAIT;
                            end
                        endcase
                    end else if (waiting && !sel_rdy) begin
                        armed <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: latency-programmable sub-block stubs plus a timeline model
// that predicts every output cycle by cycle from the stub latencies.
module tb_arc4_seq;

    localparam int TO = 1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] key;
    logic        rdy, done, err;
    logic [23:0] key_q;
    logic [1:0]  phase;
    logic        init_en, ksa_en, prga_en;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    logic [7:0]  sa[3];
    logic [7:0]  sd[3];
    logic        sw[3];
    logic        rdy_s[3];
    logic        en_v[3];
    int          st_lat[3];
    int          st_stl[3];
    bit          stuck[3];
    int          jj[3];
    bit          busy[3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign en_v[0] = init_en;
    assign en_v[1] = ksa_en;
    assign en_v[2] = prga_en;

    arc4_seq #(.TIMEOUT(32'(TO)), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
        .done(done), .err(err), .phase(phase),
        .init_en(init_en), .init_rdy(rdy_s[0]), .init_addr(sa[0]),
        .init_wrdata(sd[0]), .init_wren(sw[0]),
        .ksa_en(ksa_en), .ksa_rdy(rdy_s[1]), .ksa_addr(sa[1]),
        .ksa_wrdata(sd[1]), .ksa_wren(sw[1]),
        .prga_en(prga_en), .prga_rdy(rdy_s[2]), .prga_addr(sa[2]),
        .prga_wrdata(sd[2]), .prga_wren(sw[2]),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    // Stub: after sampling en, rdy stays high st_stl cycles, low st_lat cycles, then high.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                busy[i]  <= 1'b0;
                jj[i]    <= 0;
                rdy_s[i] <= 1'b1;
            end else if (stuck[i]) begin
                rdy_s[i] <= 1'b0;
            end else if (en_v[i]) begin
                busy[i]  <= 1'b1;
                jj[i]    <= 0;
                rdy_s[i] <= (st_stl[i] != 0);
            end else if (busy[i]) begin
                jj[i]    <= jj[i] + 1;
                rdy_s[i] <= !((st_stl[i] <= jj[i] + 1) && (jj[i] + 1 < st_stl[i] + st_lat[i]));
                if (jj[i] + 1 >= st_stl[i] + st_lat[i]) busy[i] <= 1'b0;
            end else begin
                rdy_s[i] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_stubs();
        for (int i = 0; i < 3; i++) begin
            sa[i] = 8'($urandom);
            sd[i] = 8'($urandom);
            sw[i] = 1'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, 32'(rdy), 32'd1);
        check({tag, "_phase"}, 32'(phase), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_key_q"}, 32'(key_q), 32'd0);
        check({tag, "_en"}, 32'({init_en, ksa_en, prga_en}), 32'd0);
        check({tag, "_s_port"}, 32'({s_addr, s_wrdata, s_wren}), 32'd0);
    endtask

    // poke: 0 none, 1 single en with key 123456 early in prga, 2 random en while busy.
    task automatic run_seq(input int l0, input int l1, input int l2,
                           input int s0, input int s1, input int s2,
                           input bit stuck_ksa, input logic [23:0] k,
                           input int poke, input bit mid_rst);
        int len[3];
        int start[3];
        int end_c;
        int acc;
        int p;
        bit err_x;
        logic [7:0] ea, ed;
        logic ew;
        st_lat[0] = l0; st_lat[1] = l1; st_lat[2] = l2;
        st_stl[0] = s0; st_stl[1] = s1; st_stl[2] = s2;
        stuck[1]  = stuck_ksa;
        len[0] = l0 + s0 + 3;
        len[1] = stuck_ksa ? TO + 1 : l1 + s1 + 3;
        len[2] = l2 + s2 + 3;
        for (int i = 0; i < 3; i++) start[i] = 1 << 30;
        acc   = 0;
        err_x = 1'b0;
        end_c = 0;
        for (int i = 0; i < 3; i++) begin
            if (!err_x) begin
                start[i] = acc;
                if (len[i] > TO) begin
                    err_x = 1'b1;
                    end_c = acc + TO;
                end else begin
                    acc = acc + len[i];
                end
            end
        end
        if (!err_x) end_c = acc;

        @(negedge clk);
        drive_stubs();
        #1;
        check("rdy_before_start", 32'(rdy), 32'd1);
        en  = 1'b1;
        key = k;
        @(negedge clk);
        for (int c = 0; c <= end_c + 2; c++) begin
            drive_stubs();
            en = 1'b0;
            if (poke == 1 && c == start[2] + 2) begin
                en  = 1'b1;
                key = 24'h123456;
            end
            if (poke == 2 && c < end_c && $urandom_range(15) == 0) begin
                en  = 1'b1;
                key = 24'($urandom);
            end
            #1;
            p = (c >= end_c) ? 0 : (c >= start[2]) ? 3 : (c >= start[1]) ? 2 : 1;
            if (p == 0) begin
                ea = 8'd0; ed = 8'd0; ew = 1'b0;
            end else begin
                ea = sa[p-1]; ed = sd[p-1]; ew = sw[p-1];
            end
            check("rdy", 32'(rdy), 32'(c >= end_c));
            check("phase", 32'(phase), 32'(p));
            check("done", 32'(done), 32'(c == end_c && !err_x));
            check("err", 32'(err), 32'(c >= end_c && err_x));
            check("key_q", 32'(key_q), 32'(k));
            check("init_en", 32'(init_en), 32'(c == start[0] + 1));
            check("ksa_en", 32'(ksa_en), 32'(c == start[1] + 1 && !stuck_ksa));
            check("prga_en", 32'(prga_en), 32'(c == start[2] + 1));
            check("s_addr", 32'(s_addr), 32'(ea));
            check("s_wrdata", 32'(s_wrdata), 32'(ed));
            check("s_wren", 32'(s_wren), 32'(ew));
            if (mid_rst && c == start[1] + 3) begin
                #2 rst = 1'b1;
                #1;
                check_reset_outputs("mid_rst");
                @(negedge clk);
                rst = 1'b0;
                for (int n = 0; n < 40; n++) begin
                    drive_stubs();
                    #1;
                    check("post_rst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
                    check("post_rst_rdy", 32'(rdy), 32'd1);
                    check("post_rst_phase", 32'(phase), 32'd0);
                    @(negedge clk);
                end
                stuck[1] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        en       = 1'b0;
        stuck[1] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        key = 24'd0;
        for (int i = 0; i < 3; i++) begin
            stuck[i]  = 1'b0;
            st_lat[i] = 1;
            st_stl[i] = 0;
        end
        drive_stubs();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("idle");

        run_seq(256, 768, 1000, 0, 0, 0, 1'b0, 24'h000018, 1, 1'b0);
        run_seq($urandom_range(40, 1), $urandom_range(40, 1), $urandom_range(40, 1),
                1, 2, 1, 1'b0, 24'($urandom), 0, 1'b0);
        run_seq($urandom_range(40, 1), 10, 10, 0, 0, 0, 1'b1, 24'($urandom), 0, 1'b0);
        run_seq(12, 20, 30, 0, 0, 0, 1'b0, 24'($urandom), 0, 1'b0);
        run_seq(5, TO - 3, 5, 0, 0, 0, 1'b0, 24'h0a0b0c, 0, 1'b0);
        run_seq(5, TO - 2, 5, 0, 0, 0, 1'b0, 24'h0d0e0f, 0, 1'b0);
        run_seq(5, 5, TO - 4, 0, 0, 1, 1'b0, 24'h101112, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_seq($urandom_range(60, 1), $urandom_range(60, 1), $urandom_range(60, 1),
                    $urandom_range(2), $urandom_range(2), $urandom_range(2),
                    1'b0, 24'($urandom), 2, 1'b0);
        end
        run_seq(20, 60, 20, 0, 0, 0, 1'b0, 24'h000018, 0, 1'b1);
        run_seq(8, 9, 10, 0, 0, 0, 1'b0, 24'habcdef, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
